// File: rtl/game_pkg.sv
// ============================================================================
// Module : game_pkg
// Brief  : Geometry constants and collision-detector state encoding shared
//          by the obstacle-movement, renderer and collision blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int GAME_TILE_SIZE      = 32;
    localparam int GAME_LANE_Y0        = 64;
    localparam int GAME_H_VISIBLE_AREA = 640;
    localparam int GAME_POS_W          = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_HIT       = 3'd2,
        ST_INVULN    = 3'd3,
        ST_GAME_OVER = 3'd4
    } fcd_state_e;

endpackage

`default_nettype wire

// File: rtl/tile_overlap_cmp.sv
// ============================================================================
// Module : tile_overlap_cmp
// Brief  : Combinational sprite overlap test: lane-Y match plus
//          |car_x - frog_x| < TILE_SIZE evaluated at 11 bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_overlap_cmp
    import game_pkg::*;
#(
    parameter int TILE_SIZE = GAME_TILE_SIZE,
    parameter int LANE_Y0   = GAME_LANE_Y0
) (
    input  logic [GAME_POS_W-1:0] i_car_x,
    input  logic [GAME_POS_W-1:0] i_frog_x,
    input  logic [GAME_POS_W-1:0] i_frog_y,
    input  logic [2:0]            i_lane,
    output logic                  o_lane_match,
    output logic                  o_x_overlap,
    output logic                  o_hit
);

    logic [10:0] lane_y;
    logic [10:0] car_x_ext;
    logic [10:0] frog_x_ext;
    logic [10:0] x_dist;

    assign lane_y     = 11'(LANE_Y0) + 11'(TILE_SIZE) * {8'd0, i_lane};
    assign car_x_ext  = {1'b0, i_car_x};
    assign frog_x_ext = {1'b0, i_frog_x};

    // Subtract the smaller from the larger so the distance never wraps.
    assign x_dist = (car_x_ext >= frog_x_ext) ? (car_x_ext - frog_x_ext)
                                              : (frog_x_ext - car_x_ext);

    assign o_lane_match = ({1'b0, i_frog_y} == lane_y);
    assign o_x_overlap  = (x_dist < 11'(TILE_SIZE));
    assign o_hit        = o_lane_match && o_x_overlap;

endmodule

`default_nettype wire

// File: rtl/frog_collision_detector.sv
// ============================================================================
// Module : frog_collision_detector
// Brief  : Per-frame snapshot of frog/car positions, one-lane-per-clock
//          overlap scan, lives/respawn/invulnerability/game-over control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frog_collision_detector
    import game_pkg::*;
#(
    parameter int N_LANES        = 4,
    parameter int TILE_SIZE      = GAME_TILE_SIZE,
    parameter int LANE_Y0        = GAME_LANE_Y0,
    parameter int H_VISIBLE_AREA = GAME_H_VISIBLE_AREA,
    parameter int START_LIVES    = 3,
    parameter int INVULN_FRAMES  = 60
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    input  logic                            i_Frame_Tick,
    input  logic                            i_Restart,
    input  logic [GAME_POS_W-1:0]           i_Frog_X,
    input  logic [GAME_POS_W-1:0]           i_Frog_Y,
    input  logic [GAME_POS_W*N_LANES-1:0]   i_Car_X_Packed,
    output logic                            o_Collision,
    output logic                            o_Respawn,
    output logic [1:0]                      o_Lives,
    output logic                            o_Invulnerable,
    output logic                            o_Game_Over
);

    localparam logic [2:0] C_LAST_LANE   = 3'(N_LANES - 1);
    localparam logic [1:0] C_START_LIVES = 2'(START_LIVES);
    localparam logic [7:0] C_INVULN      = 8'(INVULN_FRAMES);

    if (N_LANES < 1 || N_LANES > 8 || START_LIVES < 1 || START_LIVES > 3 ||
        INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
        H_VISIBLE_AREA > 1024 || TILE_SIZE > H_VISIBLE_AREA) begin : g_bad_params
        $error("frog_collision_detector: parameter out of range");
    end

    fcd_state_e             state_q, state_d;
    logic [2:0]             lane_q, lane_d;
    logic                   hit_q, hit_d;
    logic [GAME_POS_W-1:0]  frog_x_q, frog_x_d;
    logic [GAME_POS_W-1:0]  frog_y_q, frog_y_d;
    logic [GAME_POS_W-1:0]  car_x_q [N_LANES];
    logic [GAME_POS_W-1:0]  car_x_d [N_LANES];
    logic [1:0]             lives_q, lives_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   collision_q, collision_d;
    logic                   respawn_q, respawn_d;

    logic [GAME_POS_W-1:0]  cur_car_x;
    logic                   lane_match;
    logic                   x_overlap;
    logic                   lane_hit;
    logic                   scan_hit;

    // Lane mux feeding the single shared comparator.
    always_comb begin
        cur_car_x = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (lane_q == 3'(k)) begin
                cur_car_x = car_x_q[k];
            end
        end
    end

    tile_overlap_cmp #(
        .TILE_SIZE (TILE_SIZE),
        .LANE_Y0   (LANE_Y0)
    ) u_cmp (
        .i_car_x      (cur_car_x),
        .i_frog_x     (frog_x_q),
        .i_frog_y     (frog_y_q),
        .i_lane       (lane_q),
        .o_lane_match (lane_match),
        .o_x_overlap  (x_overlap),
        .o_hit        (lane_hit)
    );

    assign scan_hit = hit_q | lane_hit;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        hit_d       = hit_q;
        frog_x_d    = frog_x_q;
        frog_y_d    = frog_y_q;
        car_x_d     = car_x_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        collision_d = 1'b0;
        respawn_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Frame_Tick) begin
                    frog_x_d = i_Frog_X;
                    frog_y_d = i_Frog_Y;
                    for (int k = 0; k < N_LANES; k++) begin
                        car_x_d[k] = i_Car_X_Packed[GAME_POS_W*k +: GAME_POS_W];
                    end
                    hit_d   = 1'b0;
                    lane_d  = 3'd0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                hit_d = scan_hit;
                if (lane_q == C_LAST_LANE) begin
                    state_d = scan_hit ? ST_HIT : ST_IDLE;
                    // Pulses are registered so they line up with the HIT cycle.
                    collision_d = scan_hit;
                    respawn_d   = scan_hit && (lives_q > 2'd1);
                end else begin
                    lane_d = lane_q + 3'd1;
                end
            end
            ST_HIT: begin
                lives_d = lives_q - 2'd1;
                if (lives_q > 2'd1) begin
                    cnt_d   = C_INVULN;
                    state_d = ST_INVULN;
                end else begin
                    state_d = ST_GAME_OVER;
                end
            end
            ST_INVULN: begin
                if (i_Frame_Tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAME_OVER: begin
                lives_d = 2'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_Restart) begin
            state_d     = ST_IDLE;
            lane_d      = 3'd0;
            hit_d       = 1'b0;
            lives_d     = C_START_LIVES;
            cnt_d       = 8'd0;
            collision_d = 1'b0;
            respawn_d   = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            lane_q      <= 3'd0;
            hit_q       <= 1'b0;
            frog_x_q    <= '0;
            frog_y_q    <= '0;
            for (int k = 0; k < N_LANES; k++) begin
                car_x_q[k] <= '0;
            end
            lives_q     <= C_START_LIVES;
            cnt_q       <= 8'd0;
            collision_q <= 1'b0;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            hit_q       <= hit_d;
            frog_x_q    <= frog_x_d;
            frog_y_q    <= frog_y_d;
            car_x_q     <= car_x_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
            respawn_q   <= respawn_d;
        end
    end

    assign o_Collision    = collision_q;
    assign o_Respawn      = respawn_q;
    assign o_Lives        = lives_q;
    assign o_Invulnerable = (state_q == ST_INVULN);
    assign o_Game_Over    = (state_q == ST_GAME_OVER);

endmodule

`default_nettype wire

// File: doc/frog_collision_detector.md
Name: frog_collision_detector

Overview:
Downstream consumer of the per-lane obstacle X positions produced by the obstacle-movement stages. Once per video frame it snapshots all car positions and the frog position, then scans lanes one per clock for overlap. On a hit it decrements lives, requests a frog respawn and enters a frame-counted invulnerability window. At zero lives it holds game-over until restart.

Parameters:
N_LANES, 4, number of car lanes scanned (1..8)
TILE_SIZE, 32, sprite width/height in pixels; also lane pitch
LANE_Y0, 64, pixel Y of lane 0; lane k is at LANE_Y0 + k*TILE_SIZE
H_VISIBLE_AREA, 640, visible width; positions are in 0..H_VISIBLE_AREA-TILE_SIZE
START_LIVES, 3, lives loaded at reset/restart (1..3)
INVULN_FRAMES, 60, frames of invulnerability after a hit (1..255)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  synchronous active-low reset
i_Frame_Tick  in  1  one-cycle pulse, start of vertical blanking
i_Restart  in  1  one-cycle pulse, restart game
i_Frog_X  in  10  frog pixel X
i_Frog_Y  in  10  frog pixel Y
i_Car_X_Packed  in  10*N_LANES  car X for lane k in bits [10k+9:10k]
o_Collision  out  1  one-cycle pulse on accepted hit
o_Respawn  out  1  one-cycle pulse, frog must return to start
o_Lives  out  2  remaining lives
o_Invulnerable  out  1  high during invulnerability window
o_Game_Over  out  1  high while in GAME_OVER

Behaviour:
- Reset (i_Rst_L=0 at clock edge): state IDLE, o_Lives=START_LIVES, all other outputs 0, invuln counter 0, hit flag 0. Reset overrides everything, including mid-scan.
- States: IDLE, SCAN, HIT, INVULN, GAME_OVER.
- IDLE: on i_Frame_Tick (cycle T), snapshot i_Frog_X, i_Frog_Y and all car X into registers. Clear hit flag. Lane index=0. Go to SCAN.
- SCAN: cycles T+1..T+N_LANES, lane k is compared at cycle T+1+k using snapshot values only. Input changes during the scan are ignored.
- Lane match: frog_Y == LANE_Y0 + k*TILE_SIZE.
- Horizontal overlap: |car_X - frog_X| < TILE_SIZE, computed at 11 bits with no wrap-around. Overlap at exactly TILE_SIZE apart is not a hit.
- Any match sets the sticky hit flag. After the last lane: flag=1 goes to HIT, else IDLE. Latency is fixed; there is no early exit.
- HIT (single cycle, T+N_LANES+1): o_Collision=1, o_Lives decrements at the edge ending the cycle.
  - If the new lives>0: o_Respawn=1 in the same cycle, load the invuln counter with INVULN_FRAMES, go to INVULN.
  - Else go to GAME_OVER; o_Respawn stays 0.
- INVULN: o_Invulnerable=1. Each i_Frame_Tick decrements the counter and no scan occurs. When the counter reaches 0, go to IDLE on that edge. The next frame tick starts a scan.
- GAME_OVER: o_Game_Over=1, o_Lives=0, frame ticks ignored.
- i_Restart in any state (lower priority than reset): o_Lives=START_LIVES, counter and flags cleared, outputs 0, go to IDLE. Restart has priority over a same-cycle frame tick.
- i_Frame_Tick arriving in SCAN or HIT is dropped.
- o_Collision and o_Respawn are registered pulses, exactly one cycle wide.

Decomposition:
- Shared package game_pkg: state encoding, TILE_SIZE, H_VISIBLE_AREA and lane geometry constants, shared with the obstacle-movement and renderer blocks.
- One natural sub-module: tile_overlap_cmp, a combinational 11-bit |a-b|<TILE_SIZE comparator plus lane-Y match. It is instantiated once and driven by a lane mux.

Test Plan:
- Frog at (100,96) (lane 1), car1 X=120, tick at T -> o_Collision=1 at T+5, o_Respawn=1 at T+5, o_Lives 3->2, o_Invulnerable=1 from T+6.
- Frog at (100,96), car1 X=132 (distance 32) -> no collision; state back to IDLE at T+5.
- After a hit, keep the same overlap: no o_Collision for 60 ticks; o_Invulnerable drops after the 60th tick; collision fires on the 61st tick's scan.
- Three hits with INVULN_FRAMES=1 -> o_Lives 3,2,1,0; third hit gives o_Game_Over=1 and o_Respawn=0; further ticks change nothing.
- Change i_Car_X_Packed at T+2 mid-scan from overlapping to clear -> the hit is still reported, using snapshot data.
- i_Rst_L=0 at T+3 mid-scan -> next cycle IDLE, o_Lives=3, no pulse. Then i_Restart in GAME_OVER -> o_Lives=3, o_Game_Over=0.
